number_sprite_fetch: RTL and testbench

//  Bridges the VGA timing counters to the colored-number sprite ROM. Per pixel it decides if the beam is

---
 rtl/number_sprite_fetch.sv | 178 +++++++++++++++++
 tb/tb_number_sprite_fetch.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/number_sprite_fetch.sv
// number_sprite_fetch
//   Maps the VGA beam position onto a SPRITE_W x SPRITE_H sprite window,
//   generates the sprite ROM address plus color/number selects, and
//   re-aligns the returned ROM pixel with its beam position so the pixel
//   mux in front of the DAC sees a clean, delayed pixel stream.
//
// Ports
//   clk, rst_n           pixel clock, asynchronous active-low reset
//   hcount, vcount       beam column / line from the VGA timing block
//   video_on             beam inside the visible area
//   x_pos, y_pos         sprite top-left corner (latched once per frame)
//   color_in, number_in  sprite color / digit select (latched once per frame)
//   rom_addr             registered sprite ROM address
//   rom_color            registered color select to the ROM
//   rom_number           registered digit select to the ROM
//   rom_data             ROM pixel, valid ROM_LAT cycles after rom_addr
//   pixel_out            output pixel, 2+ROM_LAT cycles after the beam sample
//   pixel_valid          video_on delayed to line up with pixel_out
module number_sprite_fetch #(
  parameter int          SPRITE_W = 30,
  parameter int          SPRITE_H = 30,
  parameter int          ADDR_W   = 10,
  parameter int          ROM_LAT  = 1,
  parameter int          H_ACTIVE = 640,
  parameter int          V_ACTIVE = 480,
  parameter logic [7:0]  TRANSP   = 8'h00,
  parameter logic [7:0]  BG_COLOR = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic              video_on,
  input  logic [9:0]        x_pos,
  input  logic [9:0]        y_pos,
  input  logic [1:0]        color_in,
  input  logic [1:0]        number_in,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [1:0]        rom_color,
  output logic [1:0]        rom_number,
  input  logic [7:0]        rom_data,
  output logic [7:0]        pixel_out,
  output logic              pixel_valid
);

  localparam logic [10:0]       W11     = 11'(SPRITE_W);
  localparam logic [10:0]       H11     = 11'(SPRITE_H);
  localparam logic [10:0]       HA11    = 11'(H_ACTIVE);
  localparam logic [10:0]       VA11    = 11'(V_ACTIVE);
  localparam logic [9:0]        V_LATCH = 10'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] W_A     = ADDR_W'(SPRITE_W);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  typedef enum logic [1:0] {IDLE, WAIT, FETCH, DONE} state_t;

  // Frame-stable copies of the sprite placement/selection.
  logic [9:0]        sx_sh, sy_sh;
  logic [1:0]        color_sh, number_sh;

  logic [ADDR_W-1:0] row_base, col;
  logic [ADDR_W-1:0] row_cur, col_cur;
  logic [10:0]       h11, v11, sx11, sy11, sx_end11, sy_end11;
  logic              in_cols, in_rows, in_active, hit;
  logic              line_first, line_inner;
  state_t            state;

  logic [ROM_LAT:0]  hit_p, vid_p;

  // Transparent texels and anything outside the sprite fall back to the
  // background inside the video area and to black in blanking.
  function automatic logic [7:0] pick_pixel(input logic       hit_d,
                                            input logic       vid_d,
                                            input logic [7:0] texel);
    if (hit_d && (texel != TRANSP)) return texel;
    else if (vid_d)                 return BG_COLOR;
    else                            return 8'h00;
  endfunction

  // Window compares are widened to 11 bits so a sprite hanging past
  // column/line 1023 does not wrap around to the left/top edge.
  always_comb begin
    h11        = {1'b0, hcount};
    v11        = {1'b0, vcount};
    sx11       = {1'b0, sx_sh};
    sy11       = {1'b0, sy_sh};
    sx_end11   = sx11 + W11;
    sy_end11   = sy11 + H11;
    in_cols    = (h11 >= sx11) && (h11 < sx_end11);
    in_rows    = (v11 >= sy11) && (v11 < sy_end11);
    in_active  = (h11 < HA11) && (v11 < VA11);
    hit        = in_cols && in_rows && video_on && in_active;
    line_first = (vcount == sy_sh);
    line_inner = (v11 > sy11) && (v11 < sy_end11);
  end

  // Row base and column are resolved combinationally for the current beam
  // sample so the first texel of a line (including sx==0) already sees the
  // updated row base and the cleared column.
  always_comb begin
    row_cur = row_base;
    if (hcount == 10'd0) begin
      if (line_first)      row_cur = '0;
      else if (line_inner) row_cur = row_base + W_A;
    end
    col_cur = (hcount == sx_sh) ? '0 : col;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx_sh     <= '0;
      sy_sh     <= '0;
      color_sh  <= '0;
      number_sh <= '0;
    end else if ((hcount == 10'd0) && (vcount == V_LATCH)) begin
      sx_sh     <= x_pos;
      sy_sh     <= y_pos;
      color_sh  <= color_in;
      number_sh <= number_in;
    end
  end

  // Per-line tracker: where the beam is relative to the sprite window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (hcount == 10'd0) begin
      state <= hit ? FETCH : (in_rows ? WAIT : IDLE);
    end else begin
      case (state)
        WAIT: begin
          if (hit)                    state <= FETCH;
          else if (h11 >= sx_end11)   state <= DONE;
        end
        FETCH: begin
          if (!hit)                   state <= DONE;
        end
        default: state <= state;
      endcase
    end
  end

  // Stage p0 -> address stage: ROM request and hit/video delay line entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_base   <= '0;
      col        <= '0;
      rom_addr   <= '0;
      rom_color  <= '0;
      rom_number <= '0;
      hit_p      <= '0;
      vid_p      <= '0;
    end else begin
      row_base   <= row_cur;
      col        <= hit ? (col_cur + ONE_A) : col_cur;
      if (hit) rom_addr <= row_cur + col_cur;
      rom_color  <= color_sh;
      rom_number <= number_sh;
      hit_p[0]   <= hit;
      vid_p[0]   <= video_on;
      for (int i = 1; i <= ROM_LAT; i++) begin
        hit_p[i] <= hit_p[i-1];
        vid_p[i] <= vid_p[i-1];
      end
    end
  end

  // Output stage: ROM pixel meets its delayed hit/video flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_out   <= '0;
      pixel_valid <= 1'b0;
    end else begin
      pixel_out   <= pick_pixel(hit_p[ROM_LAT], vid_p[ROM_LAT], rom_data);
      pixel_valid <= vid_p[ROM_LAT];
    end
  end

endmodule

// File: tb/tb_number_sprite_fetch.sv
module tb_number_sprite_fetch;

  localparam int         W  = 30;
  localparam int         H  = 30;
  localparam logic [7:0] BG = 8'h1C;

  logic       clk;
  logic       rst_n;
  logic [9:0] hcount, vcount;
  logic       video_on;
  logic [9:0] x_pos, y_pos;
  logic [1:0] color_in, number_in;
  logic [9:0] rom_addr;
  logic [1:0] rom_color, rom_number;
  logic [7:0] rom_data;
  logic [7:0] pixel_out;
  logic       pixel_valid;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: the sprite placement the design should be using.
  int msx, msy, mc, mn;
  int last_addr;
  logic [8:0] expq[$];

  number_sprite_fetch #(
    .SPRITE_W(W), .SPRITE_H(H), .ADDR_W(10), .ROM_LAT(1),
    .H_ACTIVE(640), .V_ACTIVE(480), .TRANSP(8'h00), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
    .video_on(video_on), .x_pos(x_pos), .y_pos(y_pos),
    .color_in(color_in), .number_in(number_in),
    .rom_addr(rom_addr), .rom_color(rom_color), .rom_number(rom_number),
    .rom_data(rom_data), .pixel_out(pixel_out), .pixel_valid(pixel_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sprite ROM contents: addr 0 is 8'hE0, every addr%5==3 is transparent,
  // everything else is an odd value depending on color and number.
  function automatic logic [7:0] romf(input int a, input int c, input int n);
    if (a == 0)     return 8'hE0;
    if (a % 5 == 3) return 8'h00;
    return 8'((a * 7 + c * 37 + n * 11) | 1);
  endfunction

  // One-cycle registered ROM.
  always @(posedge clk) rom_data <= romf(int'(rom_addr), int'(rom_color), int'(rom_number));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    msx = 0; msy = 0; mc = 0; mn = 0;
    last_addr = 0;
    expq.delete();
    expq.push_back(9'h000);
    expq.push_back(9'h000);
  endtask

  // Drive one beam sample, predict its effect, advance a clock, check.
  task automatic step(input int h, input int v);
    logic       vid, hitm;
    int         ea;
    logic [7:0] ep, t;
    logic [8:0] e;
    vid      = (h < 640) && (v < 480);
    hcount   = 10'(h);
    vcount   = 10'(v);
    video_on = vid;
    hitm = vid && (h >= msx) && (h < msx + W) && (v >= msy) && (v < msy + H);
    ea   = (v - msy) * W + (h - msx);
    if (hitm) begin
      last_addr = ea;
      t  = romf(ea, mc, mn);
      ep = (t != 8'h00) ? t : BG;
    end else begin
      ep = vid ? BG : 8'h00;
    end
    expq.push_back({vid, ep});
    if (h == 0 && v == 480) begin
      msx = int'(x_pos); msy = int'(y_pos); mc = int'(color_in); mn = int'(number_in);
    end
    @(posedge clk);
    #1;
    chk("rom_addr", rom_addr, last_addr);
    if (hitm) begin
      chk("rom_color", rom_color, mc);
      chk("rom_number", rom_number, mn);
      chk("addr_le_899", rom_addr <= 10'd899, 1);
    end
    e = expq.pop_front();
    chk("pixel_out", pixel_out, e[7:0]);
    chk("pixel_valid", pixel_valid, e[8]);
  endtask

  task automatic scan_line(input int v, input int sx);
    int lo, hi;
    lo = (sx - 2 < 1) ? 1 : sx - 2;
    hi = (sx + W + 1 > 799) ? 799 : sx + W + 1;
    step(0, v);
    for (int h = lo; h <= hi; h++) step(h, v);
  endtask

  // Latch a new sprite at the frame boundary, then sweep the window lines.
  // Ten lines into the window the inputs are scrambled (gx for x_pos).
  task automatic frame(input int nx, input int ny, input int nc, input int nn, input int gx);
    int vlo, vhi;
    x_pos = 10'(nx); y_pos = 10'(ny); color_in = 2'(nc); number_in = 2'(nn);
    step(0, 480);
    step(1, 480);
    vlo = (ny - 2 < 0) ? 0 : ny - 2;
    vhi = (ny + H + 1 > 479) ? 479 : ny + H + 1;
    for (int v = vlo; v <= vhi; v++) begin
      if (v == ny + 10) begin
        x_pos     = 10'(gx);
        y_pos     = 10'($urandom_range(0, 500));
        color_in  = 2'($urandom_range(0, 3));
        number_in = 2'($urandom_range(0, 3));
      end
      scan_line(v, nx);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    hcount = '0; vcount = '0; video_on = 1'b0;
    x_pos = '0; y_pos = '0; color_in = '0; number_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rom_addr", rom_addr, 0);
    chk("reset_rom_color", rom_color, 0);
    chk("reset_rom_number", rom_number, 0);
    chk("reset_pixel_out", pixel_out, 0);
    chk("reset_pixel_valid", pixel_valid, 0);
    rst_n = 1'b1;

    // Directed: blue digit 3 at (100,50); x moved to 300 mid-frame.
    frame(100, 50, 2, 3, 300);
    frame(300, 50, 2, 3, 17);
    // Bottom-right clipping: 15 columns by 10 lines visible.
    frame(625, 470, 1, 2, 5);
    // Top-left corner, hit on hcount==0.
    frame(0, 0, 0, 0, 400);
    // Sprite fully below the visible area.
    frame(200, 500, 3, 1, 60);

    // Asynchronous reset in the middle of a visible line.
    step(0, 200);
    for (int h = 1; h < 20; h++) step(h, 200);
    rst_n = 1'b0;
    #1;
    chk("midreset_rom_addr", rom_addr, 0);
    chk("midreset_rom_color", rom_color, 0);
    chk("midreset_rom_number", rom_number, 0);
    chk("midreset_pixel_out", pixel_out, 0);
    chk("midreset_pixel_valid", pixel_valid, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int h = 20; h <= 40; h++) step(h, 200);

    // Randomized sprite placements.
    for (int f = 0; f < 6; f++)
      frame($urandom_range(0, 700), $urandom_range(0, 470),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 700));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
